nios2_dbg_cmd_arbiter: RTL and testbench

- Shares the single Nios II debug-slave resource (OCI memory and break/trigger registers) between NUM_REQ debug requesters in the system-clock domain.
- Requesters include the JTAG-side sequencer and the NoC debug agent.
- Requests are granted round-robin, one command at a time, with a req/ack handshake on the resource side.
- Each response is returned only to the requester that issued the command.

---
 rtl/nios2_dbg_pkg.sv | 22 ++
 rtl/nios2_dbg_rr_arb.sv | 40 ++++
 rtl/nios2_dbg_cmd_arbiter.sv | 133 +++++++++++++
 tb/tb_nios2_dbg_cmd_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug-slave command arbiter:
// opcodes, FSM state encoding and the debug data width.
package nios2_dbg_pkg;

  localparam int DBG_DATA_W = 32;

  localparam logic [1:0] OP_MEM_RD = 2'b00;
  localparam logic [1:0] OP_MEM_WR = 2'b01;
  localparam logic [1:0] OP_BRK_RD = 2'b10;
  localparam logic [1:0] OP_BRK_WR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dbg_state_e;

  function automatic logic is_write(input logic [1:0] op);
    return (op == OP_MEM_WR) || (op == OP_BRK_WR);
  endfunction

endpackage

// File: rtl/nios2_dbg_rr_arb.sv
// Combinational round-robin grant: first valid requester above last_grant,
// wrapping to the lowest valid requester when none is above it.
module nios2_dbg_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  import nios2_dbg_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] above;
  logic [NUM_REQ-1:0] pick;

  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above[i] = valid[i] && (i > int'(last_grant));
    end
  end

  assign pick = (|above) ? above : valid;

  // Descending scan so the lowest set bit of pick is the one kept.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/nios2_dbg_cmd_arbiter.sv
// Round-robin arbiter sharing the Nios II OCI debug slave between NUM_REQ
// requesters. Optional ISSUE watchdog enabled by macro DBG_ARB_TIMEOUT_EN.
module nios2_dbg_cmd_arbiter
  import nios2_dbg_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [ADDR_W*NUM_REQ-1:0]     req_addr,
  input  logic [32*NUM_REQ-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic                          oci_req,
  output logic [1:0]                    oci_op,
  output logic [ADDR_W-1:0]             oci_addr,
  output logic [31:0]                   oci_wdata,
  input  logic                          oci_ack,
  input  logic [31:0]                   oci_rdata,
  input  logic                          oci_err,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  dbg_state_e               state;
  logic [IDW-1:0]           last_grant;
  logic [NUM_REQ-1:0]       arb_grant;
  logic [IDW-1:0]           arb_idx;
  logic [1:0]               sel_op;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DBG_DATA_W-1:0]    sel_wdata;
  logic [NUM_REQ-1:0]       grant_onehot;

`ifdef DBG_ARB_TIMEOUT_EN
  logic [15:0]              to_cnt;
`endif

  nios2_dbg_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Command fields of the requester the arbiter is currently offering.
  always_comb begin
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_op    = req_op[2*i +: 2];
        sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = req_wdata[DBG_DATA_W*i +: DBG_DATA_W];
      end
    end
  end

  assign req_ready    = (state == IDLE) ? arb_grant : '0;
  assign busy         = (state != IDLE);
  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      grant_id   <= IDW'(NUM_REQ - 1);
      oci_req    <= 1'b0;
      oci_op     <= '0;
      oci_addr   <= '0;
      oci_wdata  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef DBG_ARB_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            oci_op    <= sel_op;
            oci_addr  <= sel_addr;
            oci_wdata <= sel_wdata;
            grant_id  <= arb_idx;
            oci_req   <= 1'b1;
            state     <= ISSUE;
`ifdef DBG_ARB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        ISSUE: begin
          if (oci_ack) begin
            oci_req   <= 1'b0;
            rsp_valid <= grant_onehot;
            rsp_rdata <= is_write(oci_op) ? '0 : oci_rdata;
            rsp_err   <= oci_err;
            state     <= RESP;
          end
`ifdef DBG_ARB_TIMEOUT_EN
          // Ack in the limit cycle takes the branch above and wins.
          else if (to_cnt == 16'(TIMEOUT_CYC - 1)) begin
            oci_req   <= 1'b0;
            rsp_valid <= grant_onehot;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_dbg_cmd_arbiter.sv
// Directed bench for nios2_dbg_cmd_arbiter with a response scoreboard.
module tb_nios2_dbg_cmd_arbiter;

`ifdef DBG_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [17:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        oci_req;
  logic [1:0]  oci_op;
  logic [8:0]  oci_addr;
  logic [31:0] oci_wdata;
  logic        oci_ack;
  logic [31:0] oci_rdata;
  logic        oci_err;
  logic        busy;
  logic [0:0]  grant_id;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   model_last;

  nios2_dbg_cmd_arbiter #(.NUM_REQ(2), .ADDR_W(9), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .oci_req   (oci_req),
    .oci_op    (oci_op),
    .oci_addr  (oci_addr),
    .oci_wdata (oci_wdata),
    .oci_ack   (oci_ack),
    .oci_rdata (oci_rdata),
    .oci_err   (oci_err),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] d, input logic e);
    exp_t x;
    x.vld = v; x.rdata = d; x.err = e;
    sb.push_back(x);
  endtask

  // Called in the first ISSUE cycle; returns in the RESP cycle.
  task automatic serve(input int k, input logic [31:0] rd, input logic er);
    for (int c = 0; c < k; c++) begin
      chk("oci_req_wait", oci_req, 1);
      step();
    end
    chk("oci_req_ack", oci_req, 1);
    oci_ack = 1'b1; oci_rdata = rd; oci_err = er;
    step();
    oci_ack = 1'b0; oci_rdata = '0; oci_err = 1'b0;
    chk("oci_req_drop", oci_req, 0);
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid !== 2'b00) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_rsp_valid", rsp_valid, e.vld);
          chk("sb_rsp_rdata", rsp_rdata, e.rdata);
          chk("sb_rsp_err", rsp_err, e.err);
        end
      end else begin
        chk("rsp_idle_zero", {rsp_rdata, rsp_err}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    oci_ack = 1'b0; oci_rdata = '0; oci_err = 1'b0;
    repeat (3) step();
    chk("rst_oci_req", oci_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_grant_id", grant_id, 1);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();
    chk("idle_ready", req_ready, 0);
    chk("idle_oci_addr", oci_addr, 0);
    model_last = 1;

    // Single read with a 3-cycle ack wait.
    req_valid = 2'b01; req_op[1:0] = 2'b00; req_addr[8:0] = 9'h010;
    #1;
    chk("rd_ready", req_ready, 2'b01);
    push(2'b01, 32'h12345678, 1'b0);
    step();
    req_valid = '0;
    chk("rd_oci_addr", oci_addr, 9'h010);
    chk("rd_oci_op", oci_op, 2'b00);
    chk("rd_grant_id", grant_id, 0);
    chk("rd_busy", busy, 1);
    serve(3, 32'h12345678, 1'b0);
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    step();
    model_last = 0;
    chk("rd_back_idle", busy, 0);

    // Ack while idle must be ignored.
    oci_ack = 1'b1; oci_rdata = 32'hDEADBEEF;
    step();
    oci_ack = 1'b0; oci_rdata = '0;
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_req", oci_req, 0);
    step();

    // Contention: both requesters valid continuously.
    req_valid = 2'b11; req_op = 4'b1010;
    req_addr[8:0] = 9'h020; req_addr[17:9] = 9'h021;
    for (int i = 0; i < 4; i++) begin
      int exp_g;
      exp_g = (model_last + 1) % 2;
      #1;
      chk("rr_ready", req_ready, 2'b01 << exp_g);
      push(2'b01 << exp_g, 32'hB0000000 + i, 1'b0);
      step();
      chk("rr_grant_id", grant_id, exp_g);
      chk("rr_oci_addr", oci_addr, 9'h020 + exp_g);
      chk("rr_oci_op", oci_op, 2'b10);
      serve(1, 32'hB0000000 + i, 1'b0);
      chk("rr_rsp_valid", rsp_valid, 2'b01 << exp_g);
      step();
      model_last = exp_g;
    end
    req_valid = '0;
    step();

    // Zero-wait write: rdata must be forced to zero.
    req_valid = 2'b01; req_op[1:0] = 2'b01; req_addr[8:0] = 9'h1FF;
    req_wdata[31:0] = 32'hA5A5A5A5;
    #1;
    chk("wr_ready", req_ready, 2'b01);
    push(2'b01, 32'h0, 1'b0);
    step();
    req_valid = '0;
    chk("wr_oci_wdata", oci_wdata, 32'hA5A5A5A5);
    chk("wr_oci_addr", oci_addr, 9'h1FF);
    chk("wr_oci_op", oci_op, 2'b01);
    serve(0, 32'hFFFFFFFF, 1'b0);
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    step();

    // Resource error on requester 1.
    req_valid = 2'b10; req_op[3:2] = 2'b00; req_addr[17:9] = 9'h055;
    #1;
    chk("err_ready", req_ready, 2'b10);
    push(2'b10, 32'h0BAD0BAD, 1'b1);
    step();
    req_valid = '0;
    serve(2, 32'h0BAD0BAD, 1'b1);
    chk("err_rsp_valid", rsp_valid, 2'b10);
    chk("err_rsp_err", rsp_err, 1);
    step();

    // Reset in the middle of ISSUE.
    req_valid = 2'b01; req_op[1:0] = 2'b10;
    step();
    req_valid = '0;
    chk("mid_oci_req", oci_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_oci_req", oci_req, 0);
    step();
    step();
    reset_n = 1'b1;
    chk("post_rst_grant_id", grant_id, 1);
    chk("post_rst_busy", busy, 0);
    req_valid = 2'b11; req_op = 4'b0000; req_addr[8:0] = 9'h003;
    #1;
    chk("post_rst_first", req_ready, 2'b01);
    push(2'b01, 32'h00C0FFEE, 1'b0);
    step();
    req_valid = '0;
    serve(0, 32'h00C0FFEE, 1'b0);
    step();

`ifdef DBG_ARB_TIMEOUT_EN
    // Watchdog: no ack, then a late ack that must be ignored.
    req_valid = 2'b01; req_op[1:0] = 2'b00;
    #1;
    push(2'b01, 32'h0, 1'b1);
    step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      chk("to_oci_req", oci_req, 1);
      step();
    end
    chk("to_oci_drop", oci_req, 0);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    step();
    step();
    oci_ack = 1'b1; oci_rdata = 32'h77777777;
    step();
    oci_ack = 1'b0; oci_rdata = '0;
    chk("to_late_busy", busy, 0);
    step();
`endif

    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
